pipe_skid_reg: RTL and testbench

//   Parametrised pipeline stage register with a valid/ready handshake, used between
//   any two CPU stages (IF/ID ... MEM/WB) in place of a fixed per-stage register.

---
 rtl/pipe_skid_reg.sv | 93 +++++++++
 tb/tb_pipe_skid_reg.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline stage register with optional 2-entry skid,
// synchronous flush and a saturating stall counter.
module pipe_skid_reg #(
  parameter int DATA_W  = 128,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_fire;
  logic              out_fire;

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // Skid mode keeps in_ready off the out_ready path; pass-through mode
  // lets a full slot refill in the same cycle it drains.
  generate
    if (SKID_EN) begin : g_skid
      assign in_ready = ~rst & (state != FULL);
    end else begin : g_pass
      assign in_ready = ~rst & (~out_valid | out_ready);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            skid_q <= in_data;
            state  <= FULL;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: skid and pass-through instances share stimulus,
// each checked every cycle against a small queue model.
module tb_pipe_skid_reg;

  localparam int DW = 16;
  localparam int CW = 4;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;

  logic          ir1, ov1, ir0, ov0;
  logic [DW-1:0] od1, od0;
  logic [1:0]    oc1, oc0;
  logic [CW-1:0] sc1, sc0;

  int pass_cnt = 0;
  int tot_cnt = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  pipe_skid_reg #(.DATA_W(DW), .SKID_EN(1'b1), .CNT_W(CW)) dut1 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
    .occupancy(oc1), .stall_cnt(sc1)
  );

  pipe_skid_reg #(.DATA_W(DW), .SKID_EN(1'b0), .CNT_W(CW)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0),
    .occupancy(oc0), .stall_cnt(sc0)
  );

  // model: index 1 = skid instance (2 entries), index 0 = pass-through
  logic [DW-1:0] mq [2][2];
  int            mn [2];
  logic [DW-1:0] mmain [2];
  int            mst [2];

  function automatic bit m_ready(int k);
    if (rst) return 1'b0;
    if (k == 1) return mn[1] < 2;
    return (mn[0] == 0) || out_ready;
  endfunction

  always @(posedge clk) begin
    bit ov, rdy, of, inf;
    for (int k = 0; k < 2; k++) begin
      ov  = mn[k] > 0;
      rdy = m_ready(k);
      of  = ov && out_ready;
      inf = in_valid && rdy;
      if (rst) begin
        mn[k] = 0;
        mmain[k] = '0;
        mst[k] = 0;
      end else begin
        if (ov && !out_ready && mst[k] < SMAX) mst[k]++;
        if (flush) begin
          mn[k] = 0;
        end else begin
          if (of) begin
            mq[k][0] = mq[k][1];
            mn[k]--;
          end
          if (inf) begin
            mq[k][mn[k]] = in_data;
            mn[k]++;
          end
          if (mn[k] > 0) mmain[k] = mq[k][0];
        end
      end
    end
    started <= 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("ir1", 32'(ir1), 32'(m_ready(1)));
      chk("ov1", 32'(ov1), 32'(mn[1] > 0));
      chk("od1", 32'(od1), 32'(mmain[1]));
      chk("oc1", 32'(oc1), 32'(mn[1]));
      chk("sc1", 32'(sc1), 32'(mst[1]));
      chk("ir0", 32'(ir0), 32'(m_ready(0)));
      chk("ov0", 32'(ov0), 32'(mn[0] > 0));
      chk("od0", 32'(od0), 32'(mmain[0]));
      chk("oc0", 32'(oc0), 32'(mn[0]));
      chk("sc0", 32'(sc0), 32'(mst[0]));
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rst_ir1", 32'(ir1), 32'd0);
    chk("rst_ir0", 32'(ir0), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_ir1", 32'(ir1), 32'd1);
    chk("post_ir0", 32'(ir0), 32'd1);
    chk("post_ov1", 32'(ov1), 32'd0);
    chk("post_oc1", 32'(oc1), 32'd0);
    chk("post_sc1", 32'(sc1), 32'd0);
    chk("post_od1", 32'(od1), 32'd0);

    // 2: back-to-back stream
    step(1'b1, 16'hA001, 1'b1, 1'b0);
    chk("s_a1", 32'(od1), 32'hA001);
    step(1'b1, 16'hA002, 1'b1, 1'b0);
    chk("s_a2", 32'(od1), 32'hA002);
    chk("s_oc", 32'(oc1), 32'd1);
    step(1'b1, 16'hA003, 1'b1, 1'b0);
    chk("s_a3", 32'(od0), 32'hA003);
    step(1'b1, 16'hA004, 1'b1, 1'b0);
    chk("s_a4", 32'(od1), 32'hA004);
    chk("s_v4", 32'(ov0), 32'd1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("s_end", 32'(ov1), 32'd0);

    // 3: skid fill and ordered drain
    step(1'b1, 16'h00AA, 1'b0, 1'b0);
    step(1'b1, 16'h00BB, 1'b0, 1'b0);
    chk("k_oc2", 32'(oc1), 32'd2);
    chk("k_ir0", 32'(ir1), 32'd0);
    chk("k_sc1", 32'(sc1), 32'd1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("k_hold", 32'(od1), 32'h00AA);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("k_b", 32'(od1), 32'h00BB);
    chk("k_sc2", 32'(sc1), 32'd2);
    chk("k_d0", 32'(ov0), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);

    // 4: flush while full with a drain and a new offer
    step(1'b1, 16'h0A02, 1'b0, 1'b0);
    step(1'b1, 16'h0B02, 1'b0, 1'b0);
    in_valid = 1'b1; in_data = 16'h0C0C; out_ready = 1'b1; flush = 1'b1;
    #1;
    chk("f_a", 32'(od1), 32'h0A02);
    @(posedge clk); #1;
    chk("f_ov", 32'(ov1), 32'd0);
    chk("f_oc", 32'(oc1), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("f_noc", 32'(ov1), 32'd0);
    chk("f_keep", 32'(od1), 32'h0A02);

    // 5: stall counter saturation, then flush while stalled
    step(1'b1, 16'h0D0D, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0);
    chk("sat1", 32'(sc1), 32'd15);
    chk("sat0", 32'(sc0), 32'd15);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("sat_hold", 32'(sc1), 32'd15);
    chk("sat_fl", 32'(oc1), 32'd0);

    // reset mid-operation beats flush and handshake
    step(1'b1, 16'h0E0E, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 16'h0F0F, 1'b1, 1'b1);
    chk("mr_ov", 32'(ov1), 32'd0);
    chk("mr_sc", 32'(sc1), 32'd0);
    chk("mr_od", 32'(od0), 32'd0);
    rst = 1'b0;
    step(1'b0, '0, 1'b1, 1'b0);

    // 6: pass-through refill with no bubble
    step(1'b1, 16'h1111, 1'b1, 1'b0);
    in_valid = 1'b1; in_data = 16'h2222; out_ready = 1'b1; flush = 1'b0;
    #1;
    chk("p_ir", 32'(ir0), 32'd1);
    @(posedge clk); #1;
    chk("p_f", 32'(od0), 32'h2222);
    chk("p_v", 32'(ov0), 32'd1);
    in_data = 16'h3333;
    @(posedge clk); #1;
    chk("p_g", 32'(od0), 32'h3333);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("p_end", 32'(ov0), 32'd0);
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
